// File: rtl/arith_pkg.sv
// Shared definitions for the sequential limb subtractor: FSM states and
// elaboration-time sizing helpers.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = 32'(i + 1);
    end
    return r;
  endfunction

  // Operand width must split into a whole number of limbs.
  function automatic bit limbs_ok(input int unsigned w, input int unsigned l);
    return (l != 0) && (w >= l) && ((w % l) == 0);
  endfunction

endpackage

// File: rtl/limb_sub.sv
// One LIMB-bit slice of the subtractor: d = a - b - bin with borrow out.
module limb_sub #(
  parameter int unsigned LIMB = 8
) (
  input  logic [LIMB-1:0] a,
  input  logic [LIMB-1:0] b,
  input  logic            bin,
  output logic [LIMB-1:0] d,
  output logic            bout
);

  assign {bout, d} = {1'b0, a} - {1'b0, b} - (LIMB + 1)'(bin);

endmodule

// File: rtl/seq_limb_subtractor.sv
// Multi-cycle A-B over WIDTH bits, one LIMB slice per clock with a registered
// borrow chain, optional absolute-difference mode and result flags.
module seq_limb_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LIMB  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abs_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned NLIMB = WIDTH / LIMB;
  localparam int unsigned IDXW  = (NLIMB > 1) ? clog2(NLIMB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NLIMB - 1);

  generate
    if (!limbs_ok(WIDTH, LIMB)) begin : g_bad_cfg
      $error("seq_limb_subtractor: WIDTH must be a non-zero multiple of LIMB");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_abs;
  logic [WIDTH-1:0] work;
  logic             bin;
  logic [IDXW-1:0]  idx;

  logic [31:0]      shamt;
  logic [LIMB-1:0]  a_limb;
  logic [LIMB-1:0]  b_limb;
  logic [LIMB-1:0]  d_limb;
  logic             bout;
  logic [WIDTH-1:0] limb_mask;
  logic [WIDTH-1:0] work_nxt;
  logic             ovf_raw;

  // Select the current limb and splice the slice result back into the working value.
  always_comb begin
    shamt     = 32'(idx) * LIMB;
    a_limb    = LIMB'(op_a >> shamt);
    b_limb    = LIMB'(op_b >> shamt);
    limb_mask = WIDTH'({LIMB{1'b1}}) << shamt;
    work_nxt  = (work & ~limb_mask) | (WIDTH'(d_limb) << shamt);
    ovf_raw   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (work_nxt[WIDTH-1] != op_a[WIDTH-1]);
  end

  limb_sub #(.LIMB(LIMB)) u_limb_sub (
    .a    (a_limb),
    .b    (b_limb),
    .bin  (bin),
    .d    (d_limb),
    .bout (bout)
  );

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      op_abs   <= 1'b0;
      work     <= '0;
      bin      <= 1'b0;
      idx      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_a   <= a;
            op_b   <= b;
            op_abs <= abs_mode;
            work   <= '0;
            bin    <= 1'b0;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          work <= work_nxt;
          bin  <= bout;
          idx  <= idx + IDXW'(1);
          if (idx == LAST_IDX) begin
            // Flags always describe the raw A-B, even when the magnitude follows.
            borrow   <= bout;
            overflow <= ovf_raw;
            zero     <= (work_nxt == '0);
            if (op_abs && bout) begin
              state <= NEG;
            end else begin
              diff  <= work_nxt;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        NEG: begin
          work  <= -work;
          diff  <= -work;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_limb_subtractor.sv
// Scoreboard bench for seq_limb_subtractor: driver pushes model expectations,
// a done-driven monitor pops and compares.
module tb_seq_limb_subtractor;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned LIMB  = 8;
  localparam int          NLIMB = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abs_mode = 1'b0;
  logic [WIDTH-1:0]  a = '0;
  logic [WIDTH-1:0]  b = '0;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  diff;
  logic              borrow;
  logic              overflow;
  logic              zero;

  seq_limb_subtractor #(.WIDTH(WIDTH), .LIMB(LIMB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abs_mode (abs_mode),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] diff;
    logic        borrow;
    logic        overflow;
    logic        zero;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   passes = 0;
  int   total = 0;
  int   cyc = 0;
  int   n_accepted = 0;
  int   n_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  // Reference: plain wide arithmetic on the operands.
  function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                 input logic mabs, input string name);
    exp_t        e;
    logic [31:0] raw;
    raw        = ma - mb;
    e.borrow   = (ma < mb);
    e.zero     = (ma == mb);
    e.overflow = (ma[31] != mb[31]) && (raw[31] != ma[31]);
    e.diff     = (mabs && (ma < mb)) ? (mb - ma) : raw;
    e.lat      = (mabs && (ma < mb)) ? NLIMB + 1 : NLIMB;
    e.acc      = 0;
    e.name     = name;
    return e;
  endfunction

  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_, input logic tabs,
                       input bit push, input string name);
    exp_t e;
    int   w;
    w = 0;
    @(negedge clk);
    while (busy && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (busy) begin
      check({name, "_issue_timeout"}, 32'd1, 32'd0);
      return;
    end
    start    = 1'b1;
    a        = ta;
    b        = tb_;
    abs_mode = tabs;
    @(posedge clk);
    #1;
    if (push) begin
      e     = model(ta, tb_, tabs, name);
      e.acc = cyc;
      q.push_back(e);
      n_accepted++;
    end
    start    = 1'b0;
    a        = $urandom;
    b        = $urandom;
    abs_mode = 1'($urandom);
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = q.pop_front();
        check({mon_e.name, "_diff"},     diff,                mon_e.diff);
        check({mon_e.name, "_borrow"},   32'(borrow),         32'(mon_e.borrow));
        check({mon_e.name, "_overflow"}, 32'(overflow),       32'(mon_e.overflow));
        check({mon_e.name, "_zero"},     32'(zero),           32'(mon_e.zero));
        check({mon_e.name, "_latency"},  32'(cyc - mon_e.acc), 32'(mon_e.lat));
        check({mon_e.name, "_busy"},     32'(busy),           32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          w;

    #12;
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_diff",     diff,          32'd0);
    check("rst_borrow",   32'(borrow),   32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_zero",     32'(zero),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(32'h0000_0045, 32'h0000_0039, 1'b0, 1'b1, "small_pos");
    issue(32'h0000_0039, 32'h0000_0045, 1'b0, 1'b1, "small_neg");
    issue(32'h0000_0039, 32'h0000_0045, 1'b1, 1'b1, "small_abs");
    issue(32'h0100_0000, 32'h0000_0001, 1'b0, 1'b1, "ripple");
    issue(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, "ovf");
    issue(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b1, "equal_abs");
    issue(32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1, "abs_min");

    // Start pulses during CALC and during DONE must be ignored.
    issue(32'h1234_5678, 32'h0000_0010, 1'b0, 1'b1, "ign");
    @(negedge clk);
    check("ign_busy_calc", 32'(busy), 32'd1);
    start = 1'b1; a = 32'h0; b = 32'hFFFF_FFFF; abs_mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!done && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("ign_done_seen", 32'(done), 32'd1);
    start = 1'b1; a = 32'h5; b = 32'h7; abs_mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_idle_after_done", 32'(busy), 32'd0);
    check("ign_no_second_done", 32'(done), 32'd0);
    check("ign_hold_diff", diff, 32'h1234_5668);
    repeat (3) @(negedge clk);
    check("ign_still_idle", 32'(busy), 32'd0);

    // Asynchronous reset in the second CALC cycle aborts without done.
    issue(32'hAAAA_5555, 32'h1111_2222, 1'b0, 1'b0, "rst_mid");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",     32'(busy),     32'd0);
    check("mid_rst_done",     32'(done),     32'd0);
    check("mid_rst_diff",     diff,          32'd0);
    check("mid_rst_borrow",   32'(borrow),   32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    check("mid_rst_zero",     32'(zero),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    issue(32'h0000_0100, 32'h0000_0101, 1'b1, 1'b1, "after_rst");

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 4) == 0) ? ra : 32'($urandom);
      issue(ra, rb, 1'($urandom), 1'b1, $sformatf("rand%0d", i));
    end

    w = 0;
    while (q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    check("pending_expectations", 32'(q.size()), 32'd0);
    check("done_count", 32'(n_done), 32'(n_accepted));

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
